// File: rtl/rggen_bit_field_w01sc_event_if.sv
// Register-to-bit-field access bundle: write strobe/data/mask in, read data and live value out.
interface rggen_bit_field_if #(
  parameter int WIDTH = 8
);
  logic             valid;
  logic [WIDTH-1:0] write_data;
  logic [WIDTH-1:0] write_mask;
  logic [WIDTH-1:0] read_data;
  logic [WIDTH-1:0] value;

  modport bit_field (
    input  valid,
    input  write_data,
    input  write_mask,
    output read_data,
    output value
  );
endinterface

// File: rtl/rggen_bit_field_w01sc_event.sv
// Event/status bit field: sw W0C/W1C/W0S/W1S, hw set/clear (level or edge), sticky overflow, gated irq.
// Field value updates one cycle after the qualifying cycle; irq follows value by one more cycle.
module rggen_bit_field_w01sc_event #(
  parameter int               WIDTH           = 8,
  parameter logic [WIDTH-1:0] INITIAL_VALUE   = '0,
  parameter int               SW_MODE         = 1,
  parameter bit               EDGE_DETECT     = 1'b0,
  parameter bit               OVERFLOW_ENABLE = 1'b1
)(
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  rggen_bit_field_if.bit_field bit_field_if,
  input  logic [WIDTH-1:0]     i_set,
  input  logic [WIDTH-1:0]     i_clear,
  input  logic [WIDTH-1:0]     i_enable,
  output logic [WIDTH-1:0]     o_value,
  output logic [WIDTH-1:0]     o_overflow,
  output logic [WIDTH-1:0]     o_sw_action,
  output logic                 o_irq
);
  localparam logic LVL      = (SW_MODE == 1) || (SW_MODE == 3);
  localparam bit   SET_MODE = (SW_MODE == 2) || (SW_MODE == 3);

  logic [WIDTH-1:0] r_value;
  logic [WIDTH-1:0] r_sw_action;
  logic             r_irq;
  logic [WIDTH-1:0] w_sw_hit;
  logic [WIDTH-1:0] w_sw_set;
  logic [WIDTH-1:0] w_sw_clr;
  logic [WIDTH-1:0] w_hw_set;
  logic [WIDTH-1:0] w_value_next;

  assign w_sw_hit = {WIDTH{bit_field_if.valid}} & bit_field_if.write_mask
                  & ~(bit_field_if.write_data ^ {WIDTH{LVL}});
  assign w_sw_set = SET_MODE ? w_sw_hit : '0;
  assign w_sw_clr = SET_MODE ? '0 : w_sw_hit;

  generate
    if (EDGE_DETECT) begin : g_edge
      logic [WIDTH-1:0] r_set_q;
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_set_q <= '0;
        end else begin
          r_set_q <= i_set;
        end
      end
      assign w_hw_set = i_set & ~r_set_q;
    end else begin : g_level
      assign w_hw_set = i_set;
    end
  endgenerate

  // Set terms are ORed in last so a same-cycle clear never loses an event.
  assign w_value_next = (r_value & ~(i_clear | w_sw_clr)) | w_hw_set | w_sw_set;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_value     <= INITIAL_VALUE;
      r_sw_action <= '0;
      r_irq       <= 1'b0;
    end else begin
      r_value     <= w_value_next;
      r_sw_action <= w_sw_hit;
      r_irq       <= |(r_value & i_enable);
    end
  end

  generate
    if (OVERFLOW_ENABLE) begin : g_ovf
      logic [WIDTH-1:0] r_overflow;
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_overflow <= '0;
        end else begin
          r_overflow <= (w_hw_set & r_value) | (r_overflow & ~(w_sw_clr | i_clear));
        end
      end
      assign o_overflow = r_overflow;
    end else begin : g_no_ovf
      assign o_overflow = '0;
    end
  endgenerate

  assign bit_field_if.read_data = r_value;
  assign bit_field_if.value     = r_value;
  assign o_value                = r_value;
  assign o_sw_action            = r_sw_action;
  assign o_irq                  = r_irq;
endmodule

// File: tb/tb_rggen_bit_field_w01sc_event.sv
// Directed bench: W1C level instance, W1C edge-detect instance and W0S instance on a shared clock/reset.
module tb_rggen_bit_field_w01sc_event;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  rggen_bit_field_if #(.WIDTH(8)) if_a ();
  rggen_bit_field_if #(.WIDTH(8)) if_e ();
  rggen_bit_field_if #(.WIDTH(8)) if_s ();

  logic [7:0] set_a, clr_a, en_a, val_a, ovf_a, act_a;
  logic [7:0] set_e, clr_e, en_e, val_e, ovf_e, act_e;
  logic [7:0] set_s, clr_s, en_s, val_s, ovf_s, act_s;
  logic       irq_a, irq_e, irq_s;

  rggen_bit_field_w01sc_event #(
    .WIDTH(8), .INITIAL_VALUE(8'hA5), .SW_MODE(1), .EDGE_DETECT(1'b0), .OVERFLOW_ENABLE(1'b1)
  ) u_a (
    .i_clk(clk), .i_rst_n(rst_n), .bit_field_if(if_a),
    .i_set(set_a), .i_clear(clr_a), .i_enable(en_a),
    .o_value(val_a), .o_overflow(ovf_a), .o_sw_action(act_a), .o_irq(irq_a)
  );

  rggen_bit_field_w01sc_event #(
    .WIDTH(8), .INITIAL_VALUE(8'h00), .SW_MODE(1), .EDGE_DETECT(1'b1), .OVERFLOW_ENABLE(1'b1)
  ) u_e (
    .i_clk(clk), .i_rst_n(rst_n), .bit_field_if(if_e),
    .i_set(set_e), .i_clear(clr_e), .i_enable(en_e),
    .o_value(val_e), .o_overflow(ovf_e), .o_sw_action(act_e), .o_irq(irq_e)
  );

  rggen_bit_field_w01sc_event #(
    .WIDTH(8), .INITIAL_VALUE(8'h00), .SW_MODE(2), .EDGE_DETECT(1'b0), .OVERFLOW_ENABLE(1'b1)
  ) u_s (
    .i_clk(clk), .i_rst_n(rst_n), .bit_field_if(if_s),
    .i_set(set_s), .i_clear(clr_s), .i_enable(en_s),
    .o_value(val_s), .o_overflow(ovf_s), .o_sw_action(act_s), .o_irq(irq_s)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled on the next falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    if_a.valid = 1'b0; if_a.write_data = '0; if_a.write_mask = '0;
    if_e.valid = 1'b0; if_e.write_data = '0; if_e.write_mask = '0;
    if_s.valid = 1'b0; if_s.write_data = '0; if_s.write_mask = '0;
    set_a = '0; clr_a = '0; en_a = '0;
    set_e = '0; clr_e = '0; en_e = '0;
    set_s = '0; clr_s = '0; en_s = '0;

    // Reset behaviour
    repeat (2) step();
    rst_n = 1'b1;
    chk("rst_value", val_a, 8'hA5);
    chk("rst_read_data", if_a.read_data, 8'hA5);
    chk("rst_irq", {7'b0, irq_a}, 8'h00);
    chk("rst_overflow", ovf_a, 8'h00);
    chk("rst_sw_action", act_a, 8'h00);
    step();
    chk("irq_no_enable", {7'b0, irq_a}, 8'h00);
    en_a = 8'hFF;
    step();
    chk("irq_enabled", {7'b0, irq_a}, 8'h01);

    // W1C access: clear all, then set all by hardware
    if_a.valid = 1'b1; if_a.write_data = 8'hFF; if_a.write_mask = 8'hFF;
    step();
    if_a.valid = 1'b0;
    chk("w1c_clear_all", val_a, 8'h00);
    chk("w1c_clear_all_act", act_a, 8'hFF);
    set_a = 8'hFF;
    step();
    set_a = 8'h00;
    chk("hw_set_all", val_a, 8'hFF);
    chk("hw_set_all_ovf", ovf_a, 8'h00);
    chk("hw_set_act_clear", act_a, 8'h00);
    if_a.valid = 1'b1; if_a.write_data = 8'h0F; if_a.write_mask = 8'hFF;
    step();
    if_a.valid = 1'b0;
    chk("w1c_0f", val_a, 8'hF0);
    chk("w1c_0f_act", act_a, 8'h0F);
    step();
    chk("w1c_act_one_cycle", act_a, 8'h00);
    if_a.valid = 1'b1; if_a.write_data = 8'hF0; if_a.write_mask = 8'h0F;
    step();
    if_a.valid = 1'b0;
    chk("w1c_masked_value", val_a, 8'hF0);
    chk("w1c_masked_act", act_a, 8'h00);

    // Collision: hw set vs W1C on bit0
    if_a.valid = 1'b1; if_a.write_data = 8'hFF; if_a.write_mask = 8'hFF;
    step();
    if_a.valid = 1'b0;
    set_a = 8'h01;
    step();
    set_a = 8'h00;
    chk("coll_pre_value", val_a, 8'h01);
    chk("coll_pre_ovf", ovf_a, 8'h00);
    if_a.valid = 1'b1; if_a.write_data = 8'h01; if_a.write_mask = 8'h01;
    set_a = 8'h01;
    step();
    set_a = 8'h00;
    chk("coll_value", val_a, 8'h01);
    chk("coll_ovf", ovf_a, 8'h01);
    chk("coll_irq", {7'b0, irq_a}, 8'h01);
    step();
    if_a.valid = 1'b0;
    chk("coll_clr_value", val_a, 8'h00);
    chk("coll_clr_ovf", ovf_a, 8'h00);
    step();
    chk("irq_falls", {7'b0, irq_a}, 8'h00);

    // Edge detect: i_set[3] high for 5 cycles, W1C in cycle 3
    set_e = 8'h08;
    step();
    chk("edge_c1", val_e, 8'h08);
    step();
    chk("edge_c2_hold", val_e, 8'h08);
    if_e.valid = 1'b1; if_e.write_data = 8'h08; if_e.write_mask = 8'h08;
    step();
    if_e.valid = 1'b0;
    chk("edge_c3_cleared", val_e, 8'h00);
    chk("edge_c3_act", act_e, 8'h08);
    chk("edge_c3_ovf", ovf_e, 8'h00);
    repeat (2) step();
    chk("edge_c5_stays", val_e, 8'h00);
    set_e = 8'h00;
    step();
    chk("edge_low", val_e, 8'h00);
    set_e = 8'h08;
    step();
    set_e = 8'h00;
    chk("edge_reset_again", val_e, 8'h08);

    // W0S mode
    if_s.valid = 1'b1; if_s.write_data = 8'hF0; if_s.write_mask = 8'hFF;
    step();
    if_s.valid = 1'b0;
    chk("w0s_value", val_s, 8'h0F);
    chk("w0s_act", act_s, 8'h0F);
    clr_s = 8'h03;
    step();
    clr_s = 8'h00;
    chk("w0s_hw_clear", val_s, 8'h0C);
    set_s = 8'h04;
    step();
    set_s = 8'h00;
    chk("w0s_ovf_set", ovf_s, 8'h04);
    chk("w0s_ovf_value", val_s, 8'h0C);
    if_s.valid = 1'b1; if_s.write_data = 8'hFB; if_s.write_mask = 8'h04;
    step();
    if_s.valid = 1'b0;
    chk("w0s_ovf_sticky_sw", ovf_s, 8'h04);
    clr_s = 8'h04;
    step();
    clr_s = 8'h00;
    chk("w0s_ovf_hw_clear", ovf_s, 8'h00);
    chk("w0s_hw_clear_bit2", val_s, 8'h08);

    // Async reset mid-operation
    set_a = 8'h3C;
    step();
    set_a = 8'h04;
    if_a.valid = 1'b1; if_a.write_data = 8'h01; if_a.write_mask = 8'h01;
    step();
    set_a = 8'h00;
    if_a.valid = 1'b0;
    chk("pre_rst_value", val_a, 8'h3C);
    chk("pre_rst_ovf", ovf_a, 8'h04);
    chk("pre_rst_act", act_a, 8'h01);
    chk("pre_rst_irq", {7'b0, irq_a}, 8'h01);
    #2 rst_n = 1'b0;
    #1;
    chk("async_value", val_a, 8'hA5);
    chk("async_ovf", ovf_a, 8'h00);
    chk("async_irq", {7'b0, irq_a}, 8'h00);
    chk("async_act", act_a, 8'h00);
    step();
    rst_n = 1'b1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
